// File: rtl/pmunit_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : pmunit_dispatcher_if
//  Purpose  : Host ingress and pmunit command/start signals of the dispatcher.
//             The slave modport is the dispatcher. The master modport is the
//             host/array side that drives it.
//  Revision : 1.0  initial release
// ============================================================================
interface pmunit_dispatcher_if #(
   parameter int NUM_NEARPM_UNITS = 4,
   parameter int CMD_DEPTH        = 4
);
   logic [31:0]                   HOST_CMD_WORD;
   logic                          HOST_CMD_VALID;
   logic                          HOST_CMD_READY;
   logic [NUM_NEARPM_UNITS-1:0]   UNIT_BUSY;
   logic [31:0]                   COMMAND_BUS;
   logic [NUM_NEARPM_UNITS-1:0]   COMMAND_VALID;
   logic [NUM_NEARPM_UNITS-1:0]   START_EXECUTION;
   logic [31:0]                   CURRENT_LOG_ADDR;
   logic [$clog2(CMD_DEPTH):0]    CMD_COUNT;
   logic [31:0]                   DISPATCH_COUNT;

   modport slave (
      input  HOST_CMD_WORD, HOST_CMD_VALID, UNIT_BUSY,
      output HOST_CMD_READY, COMMAND_BUS, COMMAND_VALID, START_EXECUTION,
             CURRENT_LOG_ADDR, CMD_COUNT, DISPATCH_COUNT
   );

   modport master (
      output HOST_CMD_WORD, HOST_CMD_VALID, UNIT_BUSY,
      input  HOST_CMD_READY, COMMAND_BUS, COMMAND_VALID, START_EXECUTION,
             CURRENT_LOG_ADDR, CMD_COUNT, DISPATCH_COUNT
   );
endinterface
`default_nettype wire

// File: rtl/pmunit_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : pmunit_dispatcher
//  Purpose  : Assembles host command words into whole commands in a word FIFO.
//             It picks an idle pmunit round-robin and streams the command to
//             that unit. It then pulses START_EXECUTION together with a slot
//             address from a circular log region.
//  Revision : 1.0  initial release
// ============================================================================
module pmunit_dispatcher #(
   parameter int          NUM_NEARPM_UNITS = 4,
   parameter int          COMMAND_WORDS    = 5,
   parameter int          CMD_DEPTH        = 4,
   parameter logic [31:0] LOG_BASE         = 32'h0000_0000,
   parameter logic [31:0] LOG_STRIDE       = 32'h0000_0040,
   parameter int          LOG_SLOTS        = 16
) (
   input  wire logic            clk,
   input  wire logic            reset,
   pmunit_dispatcher_if.slave   bus
);
   localparam int c_DEPTH = CMD_DEPTH * COMMAND_WORDS;
   localparam int c_PTRW  = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
   localparam int c_CNTW  = $clog2(c_DEPTH + 1);
   localparam int c_WCW   = (COMMAND_WORDS > 1) ? $clog2(COMMAND_WORDS) : 1;
   localparam int c_CCW   = $clog2(CMD_DEPTH) + 1;
   localparam int c_SELW  = (NUM_NEARPM_UNITS > 1) ? $clog2(NUM_NEARPM_UNITS) : 1;
   localparam int c_SLW   = (LOG_SLOTS > 1) ? $clog2(LOG_SLOTS) : 1;
   localparam logic [NUM_NEARPM_UNITS-1:0] c_ONE = NUM_NEARPM_UNITS'(1);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_SELECT = 3'd1;
   localparam logic [2:0] c_SEND   = 3'd2;
   localparam logic [2:0] c_START  = 3'd3;
   localparam logic [2:0] c_WAIT   = 3'd4;

   logic [31:0]                 r_mem [c_DEPTH];
   logic [c_PTRW-1:0]           r_wr_ptr, r_rd_ptr, w_rd_nxt;
   logic [c_CNTW-1:0]           r_words, w_words_nxt;
   logic [c_WCW-1:0]            r_in_cnt, r_snd_cnt;
   logic [c_CCW-1:0]            r_cmd_count;
   logic                        r_ready;
   logic [2:0]                  r_state, w_state_nxt;
   logic [c_SELW-1:0]           r_sel, r_rr, w_pick, w_idx, w_sel_nxt;
   logic                        w_found;
   logic [c_SLW-1:0]            r_slot;
   logic [3:0]                  r_tmo;
   logic [31:0]                 r_dispatch;
   logic [31:0]                 r_cmd_bus, w_cmd_bus_nxt;
   logic [31:0]                 r_log_addr, w_log_nxt;
   logic [NUM_NEARPM_UNITS-1:0] r_cmd_valid, w_cmd_valid_nxt;
   logic [NUM_NEARPM_UNITS-1:0] r_start, w_start_nxt;

   logic w_push, w_pop, w_push_last, w_pop_last;

   assign w_push      = bus.HOST_CMD_VALID & r_ready;
   assign w_pop       = (r_state == c_SEND);
   assign w_push_last = w_push && (r_in_cnt == c_WCW'(COMMAND_WORDS - 1));
   assign w_pop_last  = w_pop && (r_snd_cnt == c_WCW'(COMMAND_WORDS - 1));
   assign w_words_nxt = r_words + c_CNTW'(w_push) - c_CNTW'(w_pop);
   assign w_rd_nxt    = !w_pop ? r_rd_ptr :
                        (r_rd_ptr == c_PTRW'(c_DEPTH - 1)) ? '0 : r_rd_ptr + c_PTRW'(1);

   // Word storage; contents need no reset since pointers define validity
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.HOST_CMD_WORD;
   end

   // Ingress pointers, occupancy, registered READY and complete-command count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_words     <= '0;
         r_in_cnt    <= '0;
         r_cmd_count <= '0;
         r_ready     <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_PTRW'(c_DEPTH - 1)) ? '0 : r_wr_ptr + c_PTRW'(1);
            r_in_cnt <= w_push_last ? '0 : r_in_cnt + c_WCW'(1);
         end
         r_rd_ptr <= w_rd_nxt;
         r_words  <= w_words_nxt;
         r_ready  <= (w_words_nxt != c_CNTW'(c_DEPTH));
         if (w_push_last && !w_pop_last)      r_cmd_count <= r_cmd_count + c_CCW'(1);
         else if (!w_push_last && w_pop_last) r_cmd_count <= r_cmd_count - c_CCW'(1);
      end
   end

   // Round-robin scan from r_rr; descending loop leaves the nearest idle unit
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int i = NUM_NEARPM_UNITS - 1; i >= 0; i--) begin
         w_idx = c_SELW'((int'(r_rr) + i) % NUM_NEARPM_UNITS);
         if (!bus.UNIT_BUSY[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   // State register, dispatch bookkeeping and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= c_IDLE;
         r_sel       <= '0;
         r_rr        <= '0;
         r_snd_cnt   <= '0;
         r_tmo       <= '0;
         r_slot      <= '0;
         r_dispatch  <= '0;
         r_cmd_bus   <= '0;
         r_cmd_valid <= '0;
         r_start     <= '0;
         r_log_addr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         if (r_state == c_SELECT && w_found)
            r_rr <= (w_pick == c_SELW'(NUM_NEARPM_UNITS - 1)) ? '0 : w_pick + c_SELW'(1);
         if (r_state == c_SEND) r_snd_cnt <= w_pop_last ? '0 : r_snd_cnt + c_WCW'(1);
         r_tmo <= (r_state == c_WAIT) ? r_tmo + 4'd1 : 4'd0;
         if (r_state == c_START) begin
            r_slot     <= (r_slot == c_SLW'(LOG_SLOTS - 1)) ? '0 : r_slot + c_SLW'(1);
            r_dispatch <= r_dispatch + 32'd1;
         end
         r_cmd_bus   <= w_cmd_bus_nxt;
         r_cmd_valid <= w_cmd_valid_nxt;
         r_start     <= w_start_nxt;
         r_log_addr  <= w_log_nxt;
      end
   end

   // Next-state decision
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:   if (r_cmd_count != '0) w_state_nxt = c_SELECT;
         c_SELECT: if (w_found) w_state_nxt = c_SEND;
         c_SEND:   if (w_pop_last) w_state_nxt = c_START;
         c_START:  w_state_nxt = c_WAIT;
         c_WAIT:   if (bus.UNIT_BUSY[r_sel] || r_tmo == 4'd15) w_state_nxt = c_IDLE;
         default:  w_state_nxt = c_IDLE;
      endcase
   end

   // Output values for the coming cycle, derived from the next state
   always_comb begin
      w_sel_nxt       = (r_state == c_SELECT && w_found) ? w_pick : r_sel;
      w_cmd_valid_nxt = '0;
      w_start_nxt     = '0;
      w_cmd_bus_nxt   = '0;
      w_log_nxt       = '0;
      if (w_state_nxt == c_SEND) begin
         w_cmd_valid_nxt = c_ONE << w_sel_nxt;
         w_cmd_bus_nxt   = r_mem[w_rd_nxt];
      end
      if (w_state_nxt == c_START) w_start_nxt = c_ONE << r_sel;
      if (w_state_nxt == c_SEND || w_state_nxt == c_START)
         w_log_nxt = LOG_BASE + 32'(r_slot) * LOG_STRIDE;
   end

   assign bus.HOST_CMD_READY   = r_ready;
   assign bus.COMMAND_BUS      = r_cmd_bus;
   assign bus.COMMAND_VALID    = r_cmd_valid;
   assign bus.START_EXECUTION  = r_start;
   assign bus.CURRENT_LOG_ADDR = r_log_addr;
   assign bus.CMD_COUNT        = r_cmd_count;
   assign bus.DISPATCH_COUNT   = r_dispatch;
endmodule
`default_nettype wire

// File: tb/tb_pmunit_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmunit_dispatcher
//  Purpose  : Directed self-checking bench for pmunit_dispatcher.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pmunit_dispatcher;
   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   pmunit_dispatcher_if #(.NUM_NEARPM_UNITS(4), .CMD_DEPTH(4)) bus ();

   pmunit_dispatcher #(
      .NUM_NEARPM_UNITS(4), .COMMAND_WORDS(5), .CMD_DEPTH(4),
      .LOG_BASE(32'h0), .LOG_STRIDE(32'h40), .LOG_SLOTS(16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      bus.HOST_CMD_VALID = 1'b0;
      bus.UNIT_BUSY = 4'b0000;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic push_word(input logic [31:0] w);
      int t = 0;
      @(negedge clk);
      bus.HOST_CMD_VALID = 1'b1;
      bus.HOST_CMD_WORD  = w;
      while (!bus.HOST_CMD_READY && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         n_chk++;
         $display("FAIL push_timeout: ready never seen for word %h", w);
      end
      @(posedge clk);
      #1 bus.HOST_CMD_VALID = 1'b0;
   endtask

   task automatic push_cmd(input logic [31:0] base);
      for (int w = 0; w < 5; w++) push_word(base + 32'(w));
   endtask

   task automatic wait_start();
      int t = 0;
      @(negedge clk);
      while (bus.START_EXECUTION == 4'b0000 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         n_chk++;
         $display("FAIL start_timeout: no START_EXECUTION within %0d cycles", t);
      end
   endtask

   task automatic wait_valid();
      int t = 0;
      @(negedge clk);
      while (bus.COMMAND_VALID == 4'b0000 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         n_chk++;
         $display("FAIL valid_timeout: no COMMAND_VALID within %0d cycles", t);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_chk++; if (bus.HOST_CMD_READY !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus.HOST_CMD_READY); else n_pass++;
      n_chk++; if (bus.COMMAND_VALID !== 4'b0) $display("FAIL rst_valid: got %b want 0000", bus.COMMAND_VALID); else n_pass++;
      n_chk++; if (bus.START_EXECUTION !== 4'b0) $display("FAIL rst_start: got %b want 0000", bus.START_EXECUTION); else n_pass++;
      n_chk++; if (bus.COMMAND_BUS !== 32'h0) $display("FAIL rst_bus: got %h want 0", bus.COMMAND_BUS); else n_pass++;
      n_chk++; if (bus.CURRENT_LOG_ADDR !== 32'h0) $display("FAIL rst_log: got %h want 0", bus.CURRENT_LOG_ADDR); else n_pass++;
      n_chk++; if (bus.CMD_COUNT !== 3'd0) $display("FAIL rst_cmdcnt: got %0d want 0", bus.CMD_COUNT); else n_pass++;
      n_chk++; if (bus.DISPATCH_COUNT !== 32'd0) $display("FAIL rst_disp: got %0d want 0", bus.DISPATCH_COUNT); else n_pass++;
      reset = 1'b1;
      @(negedge clk);
      n_chk++; if (bus.HOST_CMD_READY !== 1'b1) $display("FAIL rst_ready_rise: got %b want 1", bus.HOST_CMD_READY); else n_pass++;
   endtask

   task automatic test_single();
      for (int w = 0; w < 5; w++) push_word(32'h11 + 32'(w));
      n_chk++; if (bus.CMD_COUNT !== 3'd1) $display("FAIL single_cmdcnt: got %0d want 1", bus.CMD_COUNT); else n_pass++;
      @(negedge clk);
      n_chk++; if (bus.COMMAND_VALID !== 4'b0) $display("FAIL single_idle: got %b want 0000", bus.COMMAND_VALID); else n_pass++;
      @(negedge clk);
      n_chk++; if (bus.COMMAND_VALID !== 4'b0) $display("FAIL single_select: got %b want 0000", bus.COMMAND_VALID); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_chk++; if (bus.COMMAND_VALID !== 4'b0001) $display("FAIL single_valid%0d: got %b want 0001", i, bus.COMMAND_VALID); else n_pass++;
         n_chk++; if (bus.COMMAND_BUS !== 32'h11 + 32'(i)) $display("FAIL single_bus%0d: got %h want %h", i, bus.COMMAND_BUS, 32'h11 + 32'(i)); else n_pass++;
         n_chk++; if (bus.CURRENT_LOG_ADDR !== 32'h0) $display("FAIL single_log%0d: got %h want 0", i, bus.CURRENT_LOG_ADDR); else n_pass++;
         if (i == 2) bus.UNIT_BUSY = 4'b1110;
      end
      @(negedge clk);
      n_chk++; if (bus.START_EXECUTION !== 4'b0001) $display("FAIL single_start: got %b want 0001", bus.START_EXECUTION); else n_pass++;
      n_chk++; if (bus.COMMAND_VALID !== 4'b0) $display("FAIL single_valid_at_start: got %b want 0000", bus.COMMAND_VALID); else n_pass++;
      n_chk++; if (bus.COMMAND_BUS !== 32'h0) $display("FAIL single_bus_at_start: got %h want 0", bus.COMMAND_BUS); else n_pass++;
      @(negedge clk);
      n_chk++; if (bus.START_EXECUTION !== 4'b0) $display("FAIL single_start_pulse: got %b want 0000", bus.START_EXECUTION); else n_pass++;
      n_chk++; if (bus.DISPATCH_COUNT !== 32'd1) $display("FAIL single_disp: got %0d want 1", bus.DISPATCH_COUNT); else n_pass++;
      bus.UNIT_BUSY = 4'b0000;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      do_reset();
      fork
         for (int c = 0; c < 4; c++) push_cmd(32'hA0 + 32'(c * 16));
         for (int n = 0; n < 4; n++) begin
            logic [3:0] exp_u;
            exp_u = 4'b0001 << n;
            wait_start();
            n_chk++; if (bus.START_EXECUTION !== exp_u) $display("FAIL b2b_unit%0d: got %b want %b", n, bus.START_EXECUTION, exp_u); else n_pass++;
            n_chk++; if (bus.CURRENT_LOG_ADDR !== 32'(n * 64)) $display("FAIL b2b_log%0d: got %h want %h", n, bus.CURRENT_LOG_ADDR, 32'(n * 64)); else n_pass++;
            bus.UNIT_BUSY = bus.UNIT_BUSY | exp_u;
         end
      join
      @(negedge clk);
      n_chk++; if (bus.DISPATCH_COUNT !== 32'd4) $display("FAIL b2b_disp: got %0d want 4", bus.DISPATCH_COUNT); else n_pass++;
      bus.UNIT_BUSY = 4'b0000;
   endtask

   task automatic test_full();
      do_reset();
      bus.UNIT_BUSY = 4'b1111;
      for (int c = 0; c < 4; c++) push_cmd(32'hC000_0000 + 32'(c * 16));
      @(negedge clk);
      n_chk++; if (bus.HOST_CMD_READY !== 1'b0) $display("FAIL full_ready: got %b want 0", bus.HOST_CMD_READY); else n_pass++;
      n_chk++; if (bus.CMD_COUNT !== 3'd4) $display("FAIL full_cmdcnt: got %0d want 4", bus.CMD_COUNT); else n_pass++;
      fork
         push_cmd(32'hC000_0040);
         begin
            repeat (3) @(negedge clk);
            n_chk++; if (bus.COMMAND_VALID !== 4'b0) $display("FAIL full_select_hold: got %b want 0000", bus.COMMAND_VALID); else n_pass++;
            n_chk++; if (bus.HOST_CMD_READY !== 1'b0) $display("FAIL full_ready_hold: got %b want 0", bus.HOST_CMD_READY); else n_pass++;
            bus.UNIT_BUSY = 4'b1011;
            @(negedge clk);
            n_chk++; if (bus.COMMAND_VALID !== 4'b0100) $display("FAIL full_unit2: got %b want 0100", bus.COMMAND_VALID); else n_pass++;
            n_chk++; if (bus.COMMAND_BUS !== 32'hC000_0000) $display("FAIL full_bus0: got %h want c0000000", bus.COMMAND_BUS); else n_pass++;
            n_chk++; if (bus.HOST_CMD_READY !== 1'b0) $display("FAIL full_ready_send0: got %b want 0", bus.HOST_CMD_READY); else n_pass++;
            @(negedge clk);
            n_chk++; if (bus.HOST_CMD_READY !== 1'b1) $display("FAIL full_ready_rise: got %b want 1", bus.HOST_CMD_READY); else n_pass++;
            n_chk++; if (bus.COMMAND_BUS !== 32'hC000_0001) $display("FAIL full_bus1: got %h want c0000001", bus.COMMAND_BUS); else n_pass++;
            wait_start();
            n_chk++; if (bus.START_EXECUTION !== 4'b0100) $display("FAIL full_start: got %b want 0100", bus.START_EXECUTION); else n_pass++;
         end
      join
      bus.UNIT_BUSY = 4'b0000;
   endtask

   task automatic test_log_wrap();
      do_reset();
      fork
         for (int c = 0; c < 17; c++) push_cmd(32'h100 * 32'(c));
         for (int n = 0; n < 17; n++) begin
            logic [3:0]  exp_u;
            logic [31:0] exp_a;
            exp_u = 4'b0001 << (n % 4);
            exp_a = 32'((n % 16) * 64);
            wait_start();
            n_chk++; if (bus.START_EXECUTION !== exp_u) $display("FAIL wrap_unit%0d: got %b want %b", n, bus.START_EXECUTION, exp_u); else n_pass++;
            n_chk++; if (bus.CURRENT_LOG_ADDR !== exp_a) $display("FAIL wrap_log%0d: got %h want %h", n, bus.CURRENT_LOG_ADDR, exp_a); else n_pass++;
         end
      join
      @(negedge clk);
      n_chk++; if (bus.DISPATCH_COUNT !== 32'd17) $display("FAIL wrap_disp: got %0d want 17", bus.DISPATCH_COUNT); else n_pass++;
   endtask

   task automatic test_timeout();
      int d;
      do_reset();
      fork
         begin
            push_cmd(32'h500);
            push_cmd(32'h600);
         end
         begin
            wait_start();
            n_chk++; if (bus.START_EXECUTION !== 4'b0001) $display("FAIL tmo_first: got %b want 0001", bus.START_EXECUTION); else n_pass++;
            d = 0;
            do begin
               @(negedge clk);
               d++;
            end while (bus.COMMAND_VALID == 4'b0000 && d < 40);
            n_chk++; if (d !== 19) $display("FAIL tmo_gap: got %0d cycles want 19", d); else n_pass++;
            n_chk++; if (bus.COMMAND_VALID !== 4'b0010) $display("FAIL tmo_next_unit: got %b want 0010", bus.COMMAND_VALID); else n_pass++;
            n_chk++; if (bus.COMMAND_BUS !== 32'h600) $display("FAIL tmo_next_bus: got %h want 600", bus.COMMAND_BUS); else n_pass++;
         end
      join
      repeat (30) @(negedge clk);
   endtask

   task automatic test_reset_mid_send();
      do_reset();
      push_cmd(32'hE0);
      wait_valid();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      n_chk++; if (bus.COMMAND_VALID !== 4'b0) $display("FAIL midrst_valid: got %b want 0000", bus.COMMAND_VALID); else n_pass++;
      n_chk++; if (bus.COMMAND_BUS !== 32'h0) $display("FAIL midrst_bus: got %h want 0", bus.COMMAND_BUS); else n_pass++;
      n_chk++; if (bus.CURRENT_LOG_ADDR !== 32'h0) $display("FAIL midrst_log: got %h want 0", bus.CURRENT_LOG_ADDR); else n_pass++;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_chk++; if (bus.CMD_COUNT !== 3'd0) $display("FAIL midrst_cmdcnt: got %0d want 0", bus.CMD_COUNT); else n_pass++;
      n_chk++; if (bus.HOST_CMD_READY !== 1'b1) $display("FAIL midrst_ready: got %b want 1", bus.HOST_CMD_READY); else n_pass++;
      push_cmd(32'hF0);
      wait_valid();
      n_chk++; if (bus.COMMAND_VALID !== 4'b0001) $display("FAIL midrst_unit: got %b want 0001", bus.COMMAND_VALID); else n_pass++;
      n_chk++; if (bus.COMMAND_BUS !== 32'hF0) $display("FAIL midrst_bus_fresh: got %h want f0", bus.COMMAND_BUS); else n_pass++;
      n_chk++; if (bus.CURRENT_LOG_ADDR !== 32'h0) $display("FAIL midrst_log_fresh: got %h want 0", bus.CURRENT_LOG_ADDR); else n_pass++;
      wait_start();
      n_chk++; if (bus.START_EXECUTION !== 4'b0001) $display("FAIL midrst_start: got %b want 0001", bus.START_EXECUTION); else n_pass++;
   endtask

   initial begin
      bus.HOST_CMD_WORD  = 32'h0;
      bus.HOST_CMD_VALID = 1'b0;
      bus.UNIT_BUSY      = 4'b0000;
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_log_wrap();
      test_timeout();
      test_reset_mid_send();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
